// File: rtl/dmem_line_resp.sv
// Fixed-latency 128-bit line memory serving data-cache refills, with write-back port.
// Read path is a small IDLE/WAIT/RESP sequencer timed by a down-counter.
module dmem_line_resp #(
  parameter int LINE_BITS  = 16,
  parameter int DEPTH_BITS = 8,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Dc_mem_req,
  input  logic [LINE_BITS-1:0] Dc_mem_addr,
  output logic [127:0]         MEM_data_line,
  output logic                 MEM_mem_valid,
  input  logic                 Dc_wb_we,
  input  logic [LINE_BITS-1:0] Dc_wb_addr,
  input  logic [127:0]         Dc_wb_wline,
  output logic                 Mem_busy
);

  // state  | meaning
  // S_IDLE | waiting for a line request
  // S_WAIT | counting down the access latency
  // S_RESP | response line presented, valid pulse
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int NLINES = 1 << DEPTH_BITS;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [DEPTH_BITS-1:0] r_addr, w_addr_nxt;
  logic [127:0]          r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_busy, w_busy_nxt;

  logic [127:0]          r_mem [0:NLINES-1];
  logic [DEPTH_BITS-1:0] w_wb_idx;
  logic [127:0]          w_rd_line;

  assign w_wb_idx = Dc_wb_addr[DEPTH_BITS-1:0];

  generate
    if (LINE_BITS > DEPTH_BITS) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^{Dc_mem_addr[LINE_BITS-1:DEPTH_BITS],
                             Dc_wb_addr[LINE_BITS-1:DEPTH_BITS]};
    end
  endgenerate

  // Storage is never reset; a write-back on the reset edge is discarded.
  always_ff @(posedge clk) begin
    if (Dc_wb_we && !rst) begin
      r_mem[w_wb_idx] <= Dc_wb_wline;
    end
  end

  // Write-first: a same-edge write-back to the latched line wins over storage.
  assign w_rd_line = (Dc_wb_we && (w_wb_idx == r_addr)) ? Dc_wb_wline : r_mem[r_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (Dc_mem_req) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'(LATENCY - 2);
          w_addr_nxt  = Dc_mem_addr[DEPTH_BITS-1:0];
          w_busy_nxt  = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_data_nxt  = w_rd_line;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign MEM_data_line = r_data;
  assign MEM_mem_valid = r_valid;
  assign Mem_busy      = r_busy;

endmodule
